gshare_predictor: RTL and testbench

Parametrised gshare direction predictor, successor to the per-PC 2-bit BHT. Indexes a table of saturating counters with PC bits XOR'd with a global history register (GHR). The GHR is updated speculatively at predict time and repaired on mispredict from a checkpoint carried by the pipeline. Sits beside fetch (predict port) and is trained from branch resolution in the backend (update port).

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_sat_ctr_table.sv | 41 ++++
 rtl/gshare_predictor.sv | 94 +++++++++
 tb/tb_gshare_predictor.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor helpers: index width, saturating counter arithmetic
// and reset values, reused by gshare and future tournament/BTB blocks.
package bp_pkg;

  localparam int unsigned CTR_MAX_WIDTH = 4;

  typedef logic [CTR_MAX_WIDTH-1:0] ctr_t;

  typedef enum logic [1:0] {
    GHR_HOLD,
    GHR_SPEC,
    GHR_RECOVER
  } ghr_src_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic ctr_t ctr_max(input int unsigned width);
    return ctr_t'((1 << width) - 1);
  endfunction

  // Weakly not-taken: one below the taken threshold (0 for 1-bit counters).
  function automatic ctr_t ctr_reset(input int unsigned width);
    return ctr_t'((1 << (width - 1)) - 1);
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t value, input int unsigned width);
    return (value < ctr_max(width)) ? value + 1'b1 : value;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t value);
    return (value != '0) ? value - 1'b1 : value;
  endfunction

endpackage

// File: rtl/bp_sat_ctr_table.sv
// Pattern history table of saturating counters: one combinational read port
// and one read-modify-write training port; reads see pre-update contents.
module bp_sat_ctr_table
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 2,
  localparam int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_msb,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(ctr_reset(WIDTH));

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_next;

  assign rd_msb = mem[rd_idx][WIDTH-1];

  always_comb begin
    wr_next = wr_taken ? WIDTH'(ctr_inc(ctr_t'(mem[wr_idx]), WIDTH))
                       : WIDTH'(ctr_dec(ctr_t'(mem[wr_idx])));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC bits XOR global history index a counter table;
// history is shifted speculatively at predict time and repaired on mispredict.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PHT_DEPTH = 256,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned GHR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 updt_valid,
  input  logic [31:0]          updt_pc,
  input  logic [GHR_WIDTH-1:0] updt_ghr,
  input  logic                 updt_taken,
  input  logic                 updt_mispredict,
  output logic [31:0]          mispredict_cnt
);

  localparam int unsigned IDX_W = idx_width(PHT_DEPTH);

  logic [GHR_WIDTH-1:0] ghr;
  logic [GHR_WIDTH-1:0] ghr_spec;
  logic [GHR_WIDTH-1:0] ghr_recover;
  logic [IDX_W-1:0]     pred_idx;
  logic [IDX_W-1:0]     updt_idx;
  ghr_src_e             ghr_src;
  logic                 recover;
  logic                 unused_pc_bits;

  assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign updt_idx = updt_pc[IDX_W+1:2] ^ IDX_W'(updt_ghr);
  assign pred_ghr = ghr;
  assign recover  = updt_valid && updt_mispredict;

  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            updt_pc[31:IDX_W+2], updt_pc[1:0]};

  generate
    if (GHR_WIDTH == 1) begin : g_ghr_one
      logic unused_ghr_bit;
      assign unused_ghr_bit = updt_ghr[0];
      assign ghr_spec       = pred_taken;
      assign ghr_recover    = updt_taken;
    end else begin : g_ghr_multi
      assign ghr_spec    = {ghr[GHR_WIDTH-2:0], pred_taken};
      assign ghr_recover = {updt_ghr[GHR_WIDTH-2:0], updt_taken};
    end
  endgenerate

  bp_sat_ctr_table #(
    .DEPTH (PHT_DEPTH),
    .WIDTH (CTR_WIDTH)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_idx),
    .rd_msb   (pred_taken),
    .wr_en    (updt_valid),
    .wr_idx   (updt_idx),
    .wr_taken (updt_taken)
  );

  // A resolved mispredict overrides any speculative shift in the same cycle.
  always_comb begin
    ghr_src = GHR_HOLD;
    if (recover) begin
      ghr_src = GHR_RECOVER;
    end else if (pred_valid) begin
      ghr_src = GHR_SPEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr            <= '0;
      mispredict_cnt <= '0;
    end else begin
      case (ghr_src)
        GHR_RECOVER: ghr <= ghr_recover;
        GHR_SPEC:    ghr <= ghr_spec;
        default:     ghr <= ghr;
      endcase
      if (recover) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus randomized
// traffic scored against an array-based reference model of the predictor.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [7:0]  pred_ghr;
  logic        updt_valid;
  logic [31:0] updt_pc;
  logic [7:0]  updt_ghr;
  logic        updt_taken;
  logic        updt_mispredict;
  logic [31:0] mispredict_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          m_pht [256];
  int          m_ghr;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  gshare_predictor #(
    .PHT_DEPTH (256),
    .CTR_WIDTH (2),
    .GHR_WIDTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pred_valid      (pred_valid),
    .pred_pc         (pred_pc),
    .pred_taken      (pred_taken),
    .pred_ghr        (pred_ghr),
    .updt_valid      (updt_valid),
    .updt_pc         (updt_pc),
    .updt_ghr        (updt_ghr),
    .updt_taken      (updt_taken),
    .updt_mispredict (updt_mispredict),
    .mispredict_cnt  (mispredict_cnt)
  );

  function automatic int m_idx(input logic [31:0] pc, input int g);
    return int'(pc[9:2]) ^ g;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_pht[m_idx(pc, m_ghr)] >= 2;
  endfunction

  task automatic idle();
    pred_valid      = 1'b0;
    pred_pc         = 32'h0;
    updt_valid      = 1'b0;
    updt_pc         = 32'h0;
    updt_ghr        = 8'h00;
    updt_taken      = 1'b0;
    updt_mispredict = 1'b0;
  endtask

  // Advance one clock, applying the same edge to the reference model; ends at negedge.
  task automatic tick();
    bit p;
    int i;
    p = m_pred(pred_pc);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 256; k++) m_pht[k] = 1;
      m_ghr = 0;
      m_cnt = 32'h0;
    end else begin
      if (updt_valid) begin
        i = m_idx(updt_pc, int'(updt_ghr));
        if (updt_taken && m_pht[i] < 3) m_pht[i] = m_pht[i] + 1;
        else if (!updt_taken && m_pht[i] > 0) m_pht[i] = m_pht[i] - 1;
      end
      if (updt_valid && updt_mispredict) begin
        m_ghr = (int'(updt_ghr) * 2 + int'(updt_taken)) % 256;
        m_cnt = m_cnt + 32'd1;
      end else if (pred_valid) begin
        m_ghr = (m_ghr * 2 + int'(p)) % 256;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pred_pc = 32'h0000_1000;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_pred_taken: got %0b expected 0", pred_taken);
    end
    n_checks++;
    if (pred_ghr !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_pred_ghr: got %02h expected 00", pred_ghr);
    end
    n_checks++;
    if (mispredict_cnt !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mispredict_cnt: got %0d expected 0", mispredict_cnt);
    end
  endtask

  task automatic test_saturation();
    bit exp_sat [7];
    exp_sat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    idle();
    pred_pc    = 32'h0000_0040;
    updt_valid = 1'b1;
    updt_pc    = 32'h0000_0040;
    updt_ghr   = 8'h00;
    for (int k = 0; k < 7; k++) begin
      updt_taken = (k < 4);
      tick();
      #1;
      n_checks++;
      if (pred_taken !== exp_sat[k]) begin
        n_fail++;
        $display("[TB] FAIL saturation_step%0d: got %0b expected %0b", k, pred_taken, exp_sat[k]);
      end
    end
  endtask

  task automatic test_spec_history();
    idle();
    pred_pc    = 32'h0000_0100;
    pred_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (pred_ghr !== 8'h00 || pred_taken !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL spec_hist_nt%0d: got ghr=%02h taken=%0b expected ghr=00 taken=0",
                 k, pred_ghr, pred_taken);
      end
      tick();
    end
    pred_valid = 1'b0;
    updt_valid = 1'b1;
    updt_pc    = 32'h0000_0100;
    updt_ghr   = 8'h00;
    updt_taken = 1'b1;
    tick();
    idle();
    pred_pc    = 32'h0000_0100;
    pred_valid = 1'b1;
    #1;
    n_checks++;
    if (pred_ghr !== 8'h00 || pred_taken !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL spec_hist_trained: got ghr=%02h taken=%0b expected ghr=00 taken=1",
               pred_ghr, pred_taken);
    end
    tick();
    pred_valid = 1'b0;
    #1;
    n_checks++;
    if (pred_ghr !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL spec_hist_shift: got %02h expected 01", pred_ghr);
    end
  endtask

  task automatic test_recovery();
    idle();
    updt_valid      = 1'b1;
    updt_mispredict = 1'b1;
    updt_pc         = 32'h0000_0800;
    updt_ghr        = 8'h1E;
    updt_taken      = 1'b0;
    tick();
    #1;
    n_checks++;
    if (pred_ghr !== 8'h3C || mispredict_cnt !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL recovery_setup: got ghr=%02h cnt=%0d expected ghr=3c cnt=1",
               pred_ghr, mispredict_cnt);
    end
    updt_ghr   = 8'h05;
    updt_taken = 1'b1;
    tick();
    #1;
    n_checks++;
    if (pred_ghr !== 8'h0B || mispredict_cnt !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL recovery_repair: got ghr=%02h cnt=%0d expected ghr=0b cnt=2",
               pred_ghr, mispredict_cnt);
    end
    updt_valid = 1'b0;
    updt_ghr   = 8'hFF;
    tick();
    #1;
    n_checks++;
    if (pred_ghr !== 8'h0B || mispredict_cnt !== 32'd2) begin
      n_fail++;
      $display("[TB] FAIL recovery_unqualified: got ghr=%02h cnt=%0d expected ghr=0b cnt=2",
               pred_ghr, mispredict_cnt);
    end
  endtask

  task automatic test_simultaneous();
    idle();
    pred_valid      = 1'b1;
    pred_pc         = 32'h0000_0100;
    updt_valid      = 1'b1;
    updt_mispredict = 1'b1;
    updt_pc         = 32'h0000_0800;
    updt_ghr        = 8'h80;
    updt_taken      = 1'b0;
    tick();
    idle();
    #1;
    n_checks++;
    if (pred_ghr !== 8'h00 || mispredict_cnt !== 32'd3) begin
      n_fail++;
      $display("[TB] FAIL simultaneous: got ghr=%02h cnt=%0d expected ghr=00 cnt=3",
               pred_ghr, mispredict_cnt);
    end
  endtask

  task automatic test_aliasing();
    idle();
    updt_valid = 1'b1;
    updt_pc    = 32'h0000_0040;
    updt_ghr   = 8'h10;
    updt_taken = 1'b1;
    tick();
    idle();
    pred_pc = 32'h0000_0000;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL alias_predict: got %0b expected 1", pred_taken);
    end
    updt_valid = 1'b1;
    updt_pc    = 32'h0000_0040;
    updt_ghr   = 8'h10;
    updt_taken = 1'b0;
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL alias_read_before_write: got %0b expected 1", pred_taken);
    end
    tick();
    idle();
    pred_pc = 32'h0000_0000;
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL alias_after_write: got %0b expected 0", pred_taken);
    end
  endtask

  task automatic test_random();
    bit exp_t;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst             = (cyc == 200);
      pred_valid      = 1'($urandom_range(0, 1));
      pred_pc         = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      updt_valid      = 1'($urandom_range(0, 1));
      updt_pc         = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      updt_ghr        = ($urandom_range(0, 1) == 1) ? 8'(m_ghr) : 8'($urandom());
      updt_taken      = 1'($urandom_range(0, 1));
      updt_mispredict = ($urandom_range(0, 3) == 0);
      #1;
      exp_t = m_pred(pred_pc);
      n_checks++;
      if (pred_taken !== exp_t) begin
        n_fail++;
        $display("[TB] FAIL random_taken cyc%0d pc=%08h: got %0b expected %0b",
                 cyc, pred_pc, pred_taken, exp_t);
      end
      n_checks++;
      if (pred_ghr !== 8'(m_ghr)) begin
        n_fail++;
        $display("[TB] FAIL random_ghr cyc%0d: got %02h expected %02h", cyc, pred_ghr, 8'(m_ghr));
      end
      n_checks++;
      if (mispredict_cnt !== m_cnt) begin
        n_fail++;
        $display("[TB] FAIL random_cnt cyc%0d: got %0d expected %0d", cyc, mispredict_cnt, m_cnt);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    m_ghr = 0;
    m_cnt = 32'h0;
    for (int k = 0; k < 256; k++) m_pht[k] = 1;
    @(negedge clk);
    test_reset();
    test_saturation();
    test_spec_history();
    test_recovery();
    test_simultaneous();
    test_aliasing();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
